rider_detect: RTL and testbench
===============================

RIDER_DETECT -- requirements
Module: rider_detect

Interface
REQ-001 The block SHALL have parameter MIN_RIDER_WT, default 12'h200: rider-present threshold on load-cell sum.
REQ-002 The block SHALL have parameter WT_HYSTERESIS, default 12'h040: hysteresis subtracted from MIN_RIDER_WT for the rider-absent threshold.
REQ-003 The block SHALL have port clk, input, 1: sole clock, rising edge.
REQ-004 The block SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 The block SHALL have port lft_ld, input, 12: left load-cell A2D value, unsigned.
REQ-006 The block SHALL have port rght_ld, input, 12: right load-cell A2D value, unsigned.
REQ-007 The block SHALL have port ld_vld, input, 1: single-cycle strobe that lft_ld and rght_ld are fresh.
REQ-008 The block SHALL have port en_steer, output, 1: rider is balanced long enough, so steering is enabled.
REQ-009 The block SHALL have port rider_off, output, 1: no rider on the platform; downstream balance control zeroes its integrator.

Function
REQ-010 On ld_vld=1 the block SHALL capture lft_ld and rght_ld into internal registers; all comparisons SHALL use the captured values only.
REQ-011 sum SHALL be the 13-bit unsigned value lft+rght, with no overflow loss.
REQ-012 diff SHALL be |lft-rght|, 12-bit unsigned.
REQ-013 sum_gt_min SHALL be defined as sum > MIN_RIDER_WT.
REQ-014 sum_lt_min SHALL be defined as sum < (MIN_RIDER_WT - WT_HYSTERESIS).
REQ-015 diff_gt_1_4 SHALL be defined as diff > sum>>2.
REQ-016 diff_gt_15_16 SHALL be defined as diff > sum - (sum>>4).
REQ-017 The FSM SHALL have the states IDLE, WAIT and STEER_EN.
REQ-018 In IDLE, when sum_gt_min: the FSM SHALL go to WAIT and clear the timer.
REQ-019 In WAIT, when sum_lt_min: the FSM SHALL go to IDLE.
REQ-020 In WAIT, when diff_gt_1_4 (and not sum_lt_min): the FSM SHALL clear the timer and stay in WAIT.
REQ-021 In WAIT, when the timer is full (and neither condition above holds): the FSM SHALL go to STEER_EN.
REQ-022 In WAIT, otherwise: the timer SHALL increment.
REQ-023 In STEER_EN, when sum_lt_min: the FSM SHALL go to IDLE.
REQ-024 In STEER_EN, when diff_gt_15_16 (and not sum_lt_min): the FSM SHALL go to WAIT and clear the timer.
REQ-025 In STEER_EN, otherwise: the FSM SHALL stay in STEER_EN.
REQ-026 If sum_lt_min and a diff condition are true together, sum_lt_min SHALL win.
REQ-027 The timer SHALL be a 26-bit up-counter; full SHALL mean all ones (2^26-1 cycles, ~1.34 s at 50 MHz); it SHALL saturate and never wrap.
REQ-028 en_steer and rider_off SHALL be registered; they SHALL update on the clock edge that commits the state transition.
REQ-029 en_steer SHALL be 1 iff the state is STEER_EN; rider_off SHALL be 1 iff the state is IDLE; they SHALL never both be 1.
REQ-030 Latency from ld_vld to a changed output SHALL be at most 2 cycles when no timer wait is involved.

Reset
REQ-031 rst=1 at a clock edge SHALL force state IDLE, timer 0, captured loads 0, en_steer=0, rider_off=1, including mid-WAIT and mid-STEER_EN.
REQ-032 On the first edge after rst drops, evaluation SHALL resume from IDLE using zero loads until the next ld_vld.

Configuration
REQ-033 With macro RIDER_DETECT_FAST_SIM_EN defined, the timer SHALL be 15 bits and full SHALL mean 2^15-1 cycles; without the macro, the timer SHALL be 26 bits; all other behaviour SHALL be identical in both builds.

Verification (RIDER_DETECT_FAST_SIM_EN defined)
REQ-034 Reset: rst high for 2 cycles with lft=rght=12'h300 and ld_vld pulsing -> en_steer=0 and rider_off=1 throughout.
REQ-035 Step on balanced: lft=rght=12'h180 (sum 0x300), ld_vld every 8 cycles -> rider_off falls within 2 cycles; en_steer rises 32767±10 cycles later.
REQ-036 Lean during WAIT: lft=12'h280, rght=12'h080 (diff 0x200 > 0xC0) -> en_steer stays 0 for over 40000 cycles; then lft=rght=12'h180 -> en_steer after a further ~32767 cycles.
REQ-037 Hysteresis: from STEER_EN, sum=0x1D0 (inside the band) -> en_steer stays 1; sum=0x1B0 -> en_steer=0 and rider_off=1 within 2 cycles.
REQ-038 Step off one foot: from STEER_EN, lft=12'h300, rght=12'h000 -> state WAIT, en_steer=0, rider_off=0; rght=0 with lft=0 -> IDLE.
REQ-039 Mid-operation reset: rst pulsed for 1 cycle in STEER_EN -> rider_off=1 on that edge; the timer restarts from 0 afterwards.

Source files
------------

// File: rtl/rider_detect.sv
// Rider presence / balance detector for a two-load-cell platform: a three-state FSM
// gates steering once the rider has stood balanced for a full timer period.
// Build option: define RIDER_DETECT_FAST_SIM_EN to shorten the default timer to 15 bits.
module rider_detect #(
  parameter logic [11:0] MIN_RIDER_WT  = 12'h200,
  parameter logic [11:0] WT_HYSTERESIS = 12'h040,
`ifdef RIDER_DETECT_FAST_SIM_EN
  parameter int          TIMER_W       = 15
`else
  parameter int          TIMER_W       = 26
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] lft_ld,
  input  logic [11:0] rght_ld,
  input  logic        ld_vld,
  output logic        en_steer,
  output logic        rider_off
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT     = 2'd1,
    STEER_EN = 2'd2
  } state_t;

  localparam logic [12:0] ON_THR  = {1'b0, MIN_RIDER_WT};
  localparam logic [12:0] OFF_THR = {1'b0, MIN_RIDER_WT - WT_HYSTERESIS};
  localparam logic [TIMER_W-1:0] TIMER_ONE = {{(TIMER_W-1){1'b0}}, 1'b1};

  state_t               state_q, state_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [11:0]          lft_q, rght_q;
  logic                 en_steer_q, rider_off_q;

  logic [12:0]          sum;
  logic [11:0]          diff;
  logic                 sum_gt_min, sum_lt_min;
  logic                 diff_gt_1_4, diff_gt_15_16;
  logic                 timer_full;

  // Thresholds are evaluated only on the captured samples, never on the live inputs.
  always_comb begin
    sum           = {1'b0, lft_q} + {1'b0, rght_q};
    diff          = (lft_q >= rght_q) ? (lft_q - rght_q) : (rght_q - lft_q);
    sum_gt_min    = sum > ON_THR;
    sum_lt_min    = sum < OFF_THR;
    diff_gt_1_4   = {1'b0, diff} > (sum >> 2);
    diff_gt_15_16 = {1'b0, diff} > (sum - (sum >> 4));
    timer_full    = &timer_q;
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      IDLE: begin
        if (sum_gt_min) begin
          state_d = WAIT;
          timer_d = '0;
        end
      end
      WAIT: begin
        // Losing the rider outranks any imbalance verdict.
        if (sum_lt_min) begin
          state_d = IDLE;
          timer_d = '0;
        end else if (diff_gt_1_4) begin
          timer_d = '0;
        end else if (timer_full) begin
          state_d = STEER_EN;
        end else begin
          timer_d = timer_q + TIMER_ONE;
        end
      end
      STEER_EN: begin
        if (sum_lt_min) begin
          state_d = IDLE;
          timer_d = '0;
        end else if (diff_gt_15_16) begin
          state_d = WAIT;
          timer_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      lft_q       <= '0;
      rght_q      <= '0;
      en_steer_q  <= 1'b0;
      rider_off_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      en_steer_q  <= (state_d == STEER_EN);
      rider_off_q <= (state_d == IDLE);
      if (ld_vld) begin
        lft_q  <= lft_ld;
        rght_q <= rght_ld;
      end
    end
  end

  assign en_steer  = en_steer_q;
  assign rider_off = rider_off_q;

endmodule

// File: tb/tb_rider_detect.sv
// Bench for rider_detect with a 12-bit timer (full = 4095 cycles) so every scenario
// fits a short run; output transitions are checked against a queue of expected changes.
module tb_rider_detect;

  localparam int TW   = 12;
  localparam int FULL = (1 << TW) - 1;
  localparam logic [1:0] S_IDLE  = 2'b01;  // {en_steer, rider_off}
  localparam logic [1:0] S_WAIT  = 2'b00;
  localparam logic [1:0] S_STEER = 2'b10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] lft_ld = 12'h000;
  logic [11:0] rght_ld = 12'h000;
  logic        ld_vld = 1'b0;
  logic        en_steer, rider_off;

  rider_detect #(
    .MIN_RIDER_WT (12'h200),
    .WT_HYSTERESIS(12'h040),
    .TIMER_W      (TW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .lft_ld   (lft_ld),
    .rght_ld  (rght_ld),
    .ld_vld   (ld_vld),
    .en_steer (en_steer),
    .rider_off(rider_off)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [1:0] val;
    int         lo;
    int         hi;
    string      name;
  } exp_t;

  exp_t       exp_q[$];
  int         n_checks = 0;
  int         n_fails  = 0;
  logic       mon_en   = 1'b0;
  logic [1:0] prev     = 2'b01;
  int         ph       = 0;
  int         t0       = 0;

  // Every output change must match the oldest expected change, in value and cycle window.
  always @(negedge clk) begin
    logic [1:0] cur;
    exp_t       e;
    cur = {en_steer, rider_off};
    if (mon_en && cur != prev) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fails++;
        $display("FAIL unexpected_change: got %b at cycle %0d, required no change from %b",
                 cur, cyc, prev);
      end else begin
        e = exp_q.pop_front();
        if (cur !== e.val || cyc < e.lo || cyc > e.hi || (en_steer && rider_off)) begin
          n_fails++;
          $display("FAIL %s: got %b at cycle %0d, required %b in cycles [%0d:%0d]",
                   e.name, cur, cyc, e.val, e.lo, e.hi);
        end
      end
    end
    prev = cur;
  end

  // ---------------- driver tasks ----------------
  task automatic expect_change(input string name, input logic [1:0] val, input int lo, input int hi);
    exp_t e;
    e.val = val; e.lo = lo; e.hi = hi; e.name = name;
    exp_q.push_back(e);
  endtask

  // One cycle with the regular every-8-cycles ld_vld cadence.
  task automatic tick();
    @(posedge clk); #1;
    if (ph == 7) begin
      ld_vld = 1'b1;
      ph = 0;
    end else begin
      ld_vld = 1'b0;
      ph++;
    end
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  // New loads with an immediate strobe; t0 is the cycle count just before the capture edge.
  task automatic apply(input logic [11:0] l, input logic [11:0] r);
    @(posedge clk); #1;
    lft_ld = l; rght_ld = r; ld_vld = 1'b1; ph = 0;
    t0 = cyc;
  endtask

  task automatic drain(input string name, input int budget);
    int b;
    b = 0;
    while (exp_q.size() != 0 && b < budget) begin
      tick();
      b++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fails++;
      $display("FAIL %s_timeout: %0d expected changes still pending after %0d cycles, required 0",
               name, exp_q.size(), budget);
      exp_q.delete();
    end
  endtask

  task automatic check_lvl(input string name, input logic [1:0] want);
    n_checks++;
    if ({en_steer, rider_off} !== want) begin
      n_fails++;
      $display("FAIL %s: got %b at cycle %0d, required %b", name, {en_steer, rider_off}, cyc, want);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset held with heavy loads strobed: must stay rider-off throughout.
    lft_ld = 12'h300; rght_ld = 12'h300; ld_vld = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      check_lvl("reset_hold", S_IDLE);
    end
    rst = 1'b0; ld_vld = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check_lvl("post_reset_zero_loads", S_IDLE);
    prev = S_IDLE;
    mon_en = 1'b1;

    // Step on balanced: WAIT within 2 cycles, STEER_EN after a full timer period.
    apply(12'h180, 12'h180);
    expect_change("step_on_wait", S_WAIT, t0 + 1, t0 + 2);
    expect_change("step_on_steer", S_STEER, t0 + 3 + FULL - 10, t0 + 3 + FULL + 10);
    drain("step_on", FULL + 100);

    // Hysteresis band: 0x1D0 and 0x1C0 keep steering, 0x1B0 drops to IDLE.
    apply(12'h0E8, 12'h0E8);
    run(30);
    check_lvl("hyst_1d0_hold", S_STEER);
    apply(12'h0E0, 12'h0E0);
    run(30);
    check_lvl("hyst_1c0_hold", S_STEER);
    apply(12'h0D8, 12'h0D8);
    expect_change("hyst_1b0_idle", S_IDLE, t0 + 1, t0 + 2);
    drain("hyst_drop", 20);

    // Sum exactly at MIN_RIDER_WT is not enough to leave IDLE.
    apply(12'h100, 12'h100);
    run(20);
    check_lvl("idle_sum_eq_min", S_IDLE);

    // Lean during WAIT keeps clearing the timer; balancing then restarts the full wait.
    apply(12'h280, 12'h080);
    expect_change("lean_wait", S_WAIT, t0 + 1, t0 + 2);
    run(FULL + 2000);
    drain("lean_hold", 5);
    check_lvl("lean_no_steer", S_WAIT);
    apply(12'h180, 12'h180);
    expect_change("lean_then_steer", S_STEER, t0 + 2 + FULL - 10, t0 + 2 + FULL + 10);
    drain("lean_balance", FULL + 100);

    // Moderate imbalance (diff 0x280 <= 0x2D0) keeps steering.
    apply(12'h2C0, 12'h040);
    run(20);
    check_lvl("steer_moderate_lean", S_STEER);

    // Step off one foot, then both.
    apply(12'h300, 12'h000);
    expect_change("one_foot_wait", S_WAIT, t0 + 1, t0 + 2);
    drain("one_foot", 20);
    apply(12'h000, 12'h000);
    expect_change("both_off_idle", S_IDLE, t0 + 1, t0 + 2);
    drain("both_off", 20);

    // Back to STEER_EN, then a one-cycle reset mid-operation.
    apply(12'h180, 12'h180);
    expect_change("reentry_wait", S_WAIT, t0 + 1, t0 + 2);
    expect_change("reentry_steer", S_STEER, t0 + 3 + FULL - 10, t0 + 3 + FULL + 10);
    drain("reentry", FULL + 100);
    @(posedge clk); #1;
    rst = 1'b1; ld_vld = 1'b0;
    expect_change("mid_reset_idle", S_IDLE, cyc + 1, cyc + 1);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check_lvl("mid_reset_zero_loads", S_IDLE);
    drain("mid_reset", 5);

    // Timer restarts from zero: another full period before steering.
    apply(12'h180, 12'h180);
    expect_change("restart_wait", S_WAIT, t0 + 1, t0 + 2);
    expect_change("restart_steer", S_STEER, t0 + 3 + FULL - 10, t0 + 3 + FULL + 10);
    drain("restart", FULL + 100);
    run(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
